// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing one 8-digit seven-segment display among N_REQ requesters.
// Optional forced rotation after MAX_OWN cycles of ownership: define SEG_ARB_TIMEOUT_EN.
module seg_display_arbiter #(
   parameter int          N_REQ      = 4,
   parameter int          MIN_HOLD   = 25000000,
   parameter int          MAX_OWN    = 200000000,
   parameter logic [31:0] IDLE_VALUE = 32'h0
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [N_REQ-1:0]   i_req,
   input  logic [32*N_REQ-1:0] i_data,
   output logic [N_REQ-1:0]   o_gnt,
   output logic [2:0]         o_owner,
   output logic               o_busy,
   output logic [31:0]        o_disp_value
);

   localparam int CNT_MAX = (MIN_HOLD > MAX_OWN) ? MIN_HOLD : MAX_OWN;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] HOLD_LOAD = CW'(MIN_HOLD - 1);
`ifdef SEG_ARB_TIMEOUT_EN
   localparam logic [CW-1:0] OWN_LIMIT = CW'(MAX_OWN);
`endif

   typedef enum logic [1:0] {S_IDLE, S_HOLD, S_OWN} state_t;

   state_t            r_state;
   logic [N_REQ-1:0]  r_gnt;
   logic [2:0]        r_owner;
   logic              r_busy;
   logic [31:0]       r_disp;
   logic [2:0]        r_ptr;
   logic [CW-1:0]     r_cnt;

   state_t            w_state_next;
   logic [N_REQ-1:0]  w_gnt_next;
   logic [2:0]        w_owner_next;
   logic              w_busy_next;
   logic [31:0]       w_disp_next;
   logic [2:0]        w_ptr_next;
   logic [CW-1:0]     w_cnt_next;

   // Pad request/data to 8 slots so a 3-bit owner index never selects out of range.
   logic [31:0] w_data [0:7];
   logic [7:0]  w_req;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_pad
         if (gi < N_REQ) begin : g_live
            assign w_data[gi] = i_data[32*gi +: 32];
            assign w_req[gi]  = i_req[gi];
         end else begin : g_unused
            assign w_data[gi] = '0;
            assign w_req[gi]  = 1'b0;
         end
      end
   endgenerate

   // Returns {valid, index} of the first set bit scanning start, start+1, ... mod N_REQ.
   function automatic logic [3:0] rr_pick(input logic [7:0] cand, input logic [2:0] start);
      logic [3:0] res;
      int         idx;
      res = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = int'(start) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!res[3] && cand[idx[2:0]]) res = {1'b1, idx[2:0]};
      end
      return res;
   endfunction

   logic [2:0] w_ptr_after;
   logic [7:0] w_rel_cand;
   logic [3:0] w_pick_idle;
   logic [3:0] w_pick_rel;
   logic       w_req_own;
   logic       w_others;

   assign w_ptr_after = (r_owner == 3'(N_REQ - 1)) ? 3'd0 : r_owner + 3'd1;
   assign w_rel_cand  = w_req & ~(8'd1 << r_owner);
   assign w_pick_idle = rr_pick(w_req, r_ptr);
   assign w_pick_rel  = rr_pick(w_rel_cand, w_ptr_after);
   assign w_req_own   = w_req[r_owner];
   assign w_others    = |w_rel_cand;

   logic       w_release;
   logic       w_grant;
   logic [2:0] w_grant_idx;

   always_comb begin
      w_state_next = r_state;
      w_gnt_next   = r_gnt;
      w_owner_next = r_owner;
      w_busy_next  = r_busy;
      w_disp_next  = r_disp;
      w_ptr_next   = r_ptr;
      w_cnt_next   = r_cnt;
      w_release    = 1'b0;
      w_grant      = 1'b0;
      w_grant_idx  = '0;

      case (r_state)
         S_IDLE: begin
            if (w_pick_idle[3]) begin
               w_grant     = 1'b1;
               w_grant_idx = w_pick_idle[2:0];
            end
         end
         S_HOLD: begin
            // A dropped request freezes the display but the grant survives until the hold expires.
            if (w_req_own) w_disp_next = w_data[r_owner];
            if (r_cnt == '0) begin
               if (w_req_own) begin
                  w_state_next = S_OWN;
                  w_cnt_next   = '0;
               end else begin
                  w_release = 1'b1;
               end
            end else begin
               w_cnt_next = r_cnt - CW'(1);
            end
         end
         S_OWN: begin
            if (!w_req_own) begin
               w_release = 1'b1;
            end else begin
               w_disp_next = w_data[r_owner];
`ifdef SEG_ARB_TIMEOUT_EN
               if (r_cnt == OWN_LIMIT) begin
                  if (w_others) w_release = 1'b1;
               end else begin
                  w_cnt_next = r_cnt + CW'(1);
               end
`endif
            end
         end
         default: w_state_next = S_IDLE;
      endcase

      if (w_release) begin
         w_ptr_next = w_ptr_after;
         if (w_pick_rel[3]) begin
            w_grant     = 1'b1;
            w_grant_idx = w_pick_rel[2:0];
         end else begin
            w_state_next = S_IDLE;
            w_gnt_next   = '0;
            w_busy_next  = 1'b0;
            w_disp_next  = IDLE_VALUE;
            w_cnt_next   = '0;
         end
      end

      if (w_grant) begin
         w_state_next = S_HOLD;
         w_gnt_next   = N_REQ'(1) << w_grant_idx;
         w_owner_next = w_grant_idx;
         w_busy_next  = 1'b1;
         w_cnt_next   = HOLD_LOAD;
         w_disp_next  = w_data[w_grant_idx];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_gnt   <= '0;
         r_owner <= '0;
         r_busy  <= 1'b0;
         r_disp  <= IDLE_VALUE;
         r_ptr   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_gnt   <= w_gnt_next;
         r_owner <= w_owner_next;
         r_busy  <= w_busy_next;
         r_disp  <= w_disp_next;
         r_ptr   <= w_ptr_next;
         r_cnt   <= w_cnt_next;
      end
   end

   assign o_gnt        = r_gnt;
   assign o_owner      = r_owner;
   assign o_busy       = r_busy;
   assign o_disp_value = r_disp;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter (N_REQ=4, MIN_HOLD=4, MAX_OWN=10, IDLE_VALUE=DEAD0000).
// Expectations for the forced-rotation case follow SEG_ARB_TIMEOUT_EN when it is defined.
module tb_seg_display_arbiter;

   localparam logic [31:0] IDLE = 32'hDEAD0000;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [3:0]   req = 4'b0000;
   logic [31:0]  d1 = 32'h00001234;
   logic [127:0] data;
   logic [3:0]   gnt;
   logic [2:0]   owner;
   logic         busy;
   logic [31:0]  disp;

   assign data = {32'h33330000, 32'h22220000, d1, 32'h11110000};

   always #5 clk = ~clk;

   seg_display_arbiter #(
      .N_REQ(4), .MIN_HOLD(4), .MAX_OWN(10), .IDLE_VALUE(IDLE)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_data(data),
      .o_gnt(gnt), .o_owner(owner), .o_busy(busy), .o_disp_value(disp)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = 4'b0000;
      d1    = 32'h00001234;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("rst_gnt",   32'(gnt),   32'd0);
      check("rst_busy",  32'(busy),  32'd0);
      check("rst_owner", 32'(owner), 32'd0);
      check("rst_disp",  disp,       IDLE);
   endtask

   typedef struct {
      logic [3:0]  req;
      logic [31:0] d1;
      logic [3:0]  gnt;
      logic        busy;
      logic [2:0]  owner;
      logic [31:0] disp;
   } vec_t;

   vec_t vecs [20];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Grant latency, hold with frozen display, direct hand-over, idle release, OWN hand-over.
      vecs[0]  = '{4'b0000, 32'h00001234, 4'b0000, 1'b0, 3'd0, IDLE};
      vecs[1]  = '{4'b0110, 32'h00001234, 4'b0010, 1'b1, 3'd1, 32'h00001234};
      vecs[2]  = '{4'b0110, 32'h00005678, 4'b0010, 1'b1, 3'd1, 32'h00005678};
      vecs[3]  = '{4'b0100, 32'h00009999, 4'b0010, 1'b1, 3'd1, 32'h00005678};
      vecs[4]  = '{4'b0100, 32'h00009999, 4'b0010, 1'b1, 3'd1, 32'h00005678};
      vecs[5]  = '{4'b0100, 32'h00009999, 4'b0100, 1'b1, 3'd2, 32'h22220000};
      vecs[6]  = '{4'b0100, 32'h00001234, 4'b0100, 1'b1, 3'd2, 32'h22220000};
      vecs[7]  = '{4'b0100, 32'h00001234, 4'b0100, 1'b1, 3'd2, 32'h22220000};
      vecs[8]  = '{4'b0100, 32'h00001234, 4'b0100, 1'b1, 3'd2, 32'h22220000};
      vecs[9]  = '{4'b0100, 32'h00001234, 4'b0100, 1'b1, 3'd2, 32'h22220000};
      vecs[10] = '{4'b0000, 32'h00001234, 4'b0000, 1'b0, 3'd2, IDLE};
      vecs[11] = '{4'b0000, 32'h00001234, 4'b0000, 1'b0, 3'd2, IDLE};
      vecs[12] = '{4'b0001, 32'h00001234, 4'b0001, 1'b1, 3'd0, 32'h11110000};
      vecs[13] = '{4'b0001, 32'h00001234, 4'b0001, 1'b1, 3'd0, 32'h11110000};
      vecs[14] = '{4'b0001, 32'h00001234, 4'b0001, 1'b1, 3'd0, 32'h11110000};
      vecs[15] = '{4'b0001, 32'h00001234, 4'b0001, 1'b1, 3'd0, 32'h11110000};
      vecs[16] = '{4'b0001, 32'h00001234, 4'b0001, 1'b1, 3'd0, 32'h11110000};
      vecs[17] = '{4'b0001, 32'h00001234, 4'b0001, 1'b1, 3'd0, 32'h11110000};
      vecs[18] = '{4'b1000, 32'h00001234, 4'b1000, 1'b1, 3'd3, 32'h33330000};
      vecs[19] = '{4'b1000, 32'h00001234, 4'b1000, 1'b1, 3'd3, 32'h33330000};

      do_reset();

      for (int i = 0; i < 20; i++) begin
         req = vecs[i].req;
         d1  = vecs[i].d1;
         step();
         check($sformatf("vec%0d_gnt", i),   32'(gnt),   32'(vecs[i].gnt));
         check($sformatf("vec%0d_busy", i),  32'(busy),  32'(vecs[i].busy));
         check($sformatf("vec%0d_owner", i), 32'(owner), 32'(vecs[i].owner));
         check($sformatf("vec%0d_disp", i),  disp,       vecs[i].disp);
         $display("vec %0d req=%b gnt=%b busy=%b owner=%0d disp=%h", i, req, gnt, busy, owner, disp);
      end

      // Everyone requesting; each owner drops for one cycle after six granted cycles.
      do_reset();
      req = 4'b1111;
      step();
      for (int g = 0; g < 5; g++) begin
         logic [3:0] exp_gnt;
         exp_gnt = 4'b0001 << (g % 4);
         check($sformatf("rr_order%0d", g), 32'(gnt), 32'(exp_gnt));
         $display("rr grant %0d gnt=%b owner=%0d", g, gnt, owner);
         for (int c = 1; c < 6; c++) begin
            step();
            check($sformatf("rr_keep%0d_%0d", g, c), 32'(gnt), 32'(exp_gnt));
         end
         req = 4'b1111 & ~exp_gnt;
         step();
         req = 4'b1111;
      end

      // Owner keeps requesting while a competitor waits.
      do_reset();
      req = 4'b0001;
      step();
      check("to_first_gnt", 32'(gnt), 32'd1);
      req = 4'b0101;
      begin
         int waited;
         waited = 0;
         while (gnt == 4'b0001 && waited < 120) begin
            step();
            waited++;
         end
`ifdef SEG_ARB_TIMEOUT_EN
         check("to_cycles", 32'(waited), 32'd15);
         check("to_new_gnt", 32'(gnt), 32'b0100);
         check("to_new_owner", 32'(owner), 32'd2);
`else
         check("noto_cycles", 32'(waited), 32'd120);
         check("noto_gnt", 32'(gnt), 32'b0001);
`endif
         $display("timeout test waited=%0d gnt=%b", waited, gnt);
      end

      // Asynchronous reset in the middle of a grant, between clock edges.
      check("pre_rst_busy", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_gnt",   32'(gnt),   32'd0);
      check("async_busy",  32'(busy),  32'd0);
      check("async_owner", 32'(owner), 32'd0);
      check("async_disp",  disp,       IDLE);
      $display("async reset gnt=%b busy=%b disp=%h", gnt, busy, disp);
      @(negedge clk);
      rst_n = 1'b1;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
